// File: rtl/multi_ram_bank_pkg.sv
// Shared definitions for the banked RAM: controller state encoding and
// the bank-select width derivation.
package multi_ram_bank_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_t;

  // Bank-select width: ceil(log2(num_banks)), never narrower than one bit.
  function automatic int calc_bank_bit(input int num_banks);
    int b;
    b = 0;
    for (int i = 0; i < 5; i++) begin
      if ((1 << b) < num_banks) b++;
    end
    return (b < 1) ? 1 : b;
  endfunction

endpackage

// File: rtl/multi_ram_bank_bank_mem.sv
// One RAM bank: single write port plus a registered read port that holds
// its value between reads and forwards same-address write data.
module bank_mem #(
  parameter int ADDR_BIT   = 3,
  parameter int DATA_BIT   = 16,
  parameter int MEM_HEIGHT = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [ADDR_BIT-1:0] waddr,
  input  logic [DATA_BIT-1:0] wdata,
  input  logic                re,
  input  logic [ADDR_BIT-1:0] raddr,
  output logic [DATA_BIT-1:0] rdata
);

  logic [DATA_BIT-1:0] mem [MEM_HEIGHT];

  // Storage has no reset; the controller clears it row by row.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
    end
  end

endmodule

// File: rtl/multi_ram_bank.sv
// Multi-bank RAM with a row-clearing INIT pass after reset, one write and one
// read port (1-cycle read latency, write-first), and out-of-range error pulse.
module multi_ram_bank
  import multi_ram_bank_pkg::*;
#(
  parameter int ADDR_BIT     = 3,
  parameter int DATA_BIT     = 16,
  parameter int MEM_HEIGHT   = 8,
  parameter int NUM_BANKS    = 4,
  localparam int BANK_BIT    = calc_bank_bit(NUM_BANKS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         we,
  input  logic                         re,
  input  logic [BANK_BIT+ADDR_BIT-1:0] addr_w,
  input  logic [DATA_BIT-1:0]          d_w,
  input  logic [BANK_BIT+ADDR_BIT-1:0] addr_r,
  output logic [DATA_BIT-1:0]          d_r,
  output logic                         rd_valid,
  output logic                         busy,
  output logic                         err
);

  localparam logic [ADDR_BIT-1:0] LAST_ROW = ADDR_BIT'(MEM_HEIGHT - 1);
  localparam logic [BANK_BIT:0]   NB       = (BANK_BIT + 1)'(NUM_BANKS);
  localparam logic [ADDR_BIT:0]   MH       = (ADDR_BIT + 1)'(MEM_HEIGHT);

  state_t              state_q, state_d;
  logic [ADDR_BIT-1:0] cnt_q, cnt_d;
  logic                clear;
  logic                ready;

  logic [BANK_BIT-1:0] w_bank, r_bank, rd_bank_q;
  logic [ADDR_BIT-1:0] w_row, r_row;
  logic                w_ok, r_ok;
  logic                wr_acc, rd_acc;

  logic [DATA_BIT-1:0] bank_rdata [NUM_BANKS];

  assign w_bank = addr_w[BANK_BIT+ADDR_BIT-1 -: BANK_BIT];
  assign w_row  = addr_w[ADDR_BIT-1:0];
  assign r_bank = addr_r[BANK_BIT+ADDR_BIT-1 -: BANK_BIT];
  assign r_row  = addr_r[ADDR_BIT-1:0];

  assign w_ok = ({1'b0, w_bank} < NB) && ({1'b0, w_row} < MH);
  assign r_ok = ({1'b0, r_bank} < NB) && ({1'b0, r_row} < MH);

  assign ready  = (state_q == READY);
  assign busy   = ~ready;
  // Reset outranks any request presented on the same edge.
  assign wr_acc = ready & en & we & w_ok & ~rst;
  assign rd_acc = ready & en & re & r_ok & ~rst;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clear   = 1'b0;
    case (state_q)
      INIT: begin
        clear = 1'b1;
        if (cnt_q == LAST_ROW) begin
          state_d = READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      READY: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= INIT;
      cnt_q     <= '0;
      rd_valid  <= 1'b0;
      err       <= 1'b0;
      rd_bank_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rd_valid <= rd_acc;
      err      <= ready & en & ((we & ~w_ok) | (re & ~r_ok));
      if (rd_acc) rd_bank_q <= r_bank;
    end
  end

  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
    localparam logic [BANK_BIT-1:0] IDX = BANK_BIT'(gi);

    logic                b_we;
    logic                b_re;
    logic [ADDR_BIT-1:0] b_waddr;
    logic [DATA_BIT-1:0] b_wdata;

    // During INIT every bank clears the same row at once.
    assign b_we    = (clear & ~rst) | (wr_acc & (w_bank == IDX));
    assign b_waddr = clear ? cnt_q : w_row;
    assign b_wdata = clear ? '0 : d_w;
    assign b_re    = rd_acc & (r_bank == IDX);

    bank_mem #(
      .ADDR_BIT  (ADDR_BIT),
      .DATA_BIT  (DATA_BIT),
      .MEM_HEIGHT(MEM_HEIGHT)
    ) u_bank (
      .clk  (clk),
      .rst  (rst),
      .we   (b_we),
      .waddr(b_waddr),
      .wdata(b_wdata),
      .re   (b_re),
      .raddr(r_row),
      .rdata(bank_rdata[gi])
    );
  end

  // Each bank holds its last read word, so selecting by the last accepted
  // read bank keeps d_r stable when no read is accepted.
  assign d_r = bank_rdata[rd_bank_q];

endmodule

// File: tb/tb_multi_ram_bank.sv
// Directed self-checking bench: default instance plus a MEM_HEIGHT=6 instance
// driven by the same stimulus.
module tb_multi_ram_bank;

  logic        clk;
  logic        rst;
  logic        en;
  logic        we;
  logic        re;
  logic [4:0]  addr_w;
  logic [15:0] d_w;
  logic [4:0]  addr_r;

  logic [15:0] d_r, d_r6;
  logic        rd_valid, rd_valid6;
  logic        busy, busy6;
  logic        err, err6;

  int n_checks;
  int n_fail;

  multi_ram_bank dut (
    .clk(clk), .rst(rst), .en(en), .we(we), .re(re),
    .addr_w(addr_w), .d_w(d_w), .addr_r(addr_r),
    .d_r(d_r), .rd_valid(rd_valid), .busy(busy), .err(err)
  );

  multi_ram_bank #(.MEM_HEIGHT(6)) dut6 (
    .clk(clk), .rst(rst), .en(en), .we(we), .re(re),
    .addr_w(addr_w), .d_w(d_w), .addr_r(addr_r),
    .d_r(d_r6), .rd_valid(rd_valid6), .busy(busy6), .err(err6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Counts consecutive busy samples starting from the current one.
  task automatic count_busy(output int cnt, output logic seen_flag);
    cnt = 0;
    seen_flag = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!busy) break;
      cnt++;
      seen_flag = seen_flag | rd_valid | err;
      tick();
    end
  endtask

  task automatic do_read(input logic [4:0] a);
    we = 1'b0; re = 1'b1; addr_r = a;
    tick();
    re = 1'b0;
  endtask

  int   bcnt;
  logic seen;

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst = 1'b1; en = 1'b0; we = 1'b0; re = 1'b0;
    addr_w = '0; addr_r = '0; d_w = '0;

    // Reset state
    tick();
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_d_r", 32'(d_r), 32'h0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_err", 32'(err), 32'd0);

    // INIT lasts exactly MEM_HEIGHT cycles; requests during INIT are ignored
    rst = 1'b0; en = 1'b1; re = 1'b1; addr_r = 5'h01;
    count_busy(bcnt, seen);
    check("init_busy_cycles", 32'(bcnt), 32'd8);
    check("init_ignored_flags", 32'(seen), 32'd0);
    check("ready_busy", 32'(busy), 32'd0);
    check("dut6_ready_busy", 32'(busy6), 32'd0);

    // Every address reads back cleared
    for (int a = 0; a < 32; a++) begin
      addr_r = 5'(a);
      re = 1'b1;
      tick();
      check($sformatf("clr_d_r_%0h", a), 32'(d_r), 32'h0);
      check($sformatf("clr_valid_%0h", a), 32'(rd_valid), 32'd1);
    end
    re = 1'b0;
    tick();
    check("idle_rd_valid", 32'(rd_valid), 32'd0);

    // Write then read, and bank isolation
    we = 1'b1; addr_w = 5'h0A; d_w = 16'h1234;
    tick();
    we = 1'b0;
    do_read(5'h0A);
    check("wr_rd_0A", 32'(d_r), 32'h1234);
    check("wr_rd_0A_valid", 32'(rd_valid), 32'd1);
    do_read(5'h1A);
    check("isolate_1A", 32'(d_r), 32'h0);

    // Write-first on same address
    we = 1'b1; addr_w = 5'h13; d_w = 16'hBEEF; re = 1'b1; addr_r = 5'h13;
    tick();
    check("wfirst_13", 32'(d_r), 32'hBEEF);
    check("wfirst_valid", 32'(rd_valid), 32'd1);

    // Concurrent write and read to different banks
    we = 1'b1; addr_w = 5'h04; d_w = 16'h4444; re = 1'b1; addr_r = 5'h0A;
    tick();
    check("dual_rd_0A", 32'(d_r), 32'h1234);
    do_read(5'h04);
    check("dual_wr_04", 32'(d_r), 32'h4444);

    // en=0 leaves memory and outputs untouched
    we = 1'b1; addr_w = 5'h02; d_w = 16'h7777;
    tick();
    en = 1'b0; we = 1'b1; re = 1'b1; addr_w = 5'h02; addr_r = 5'h02; d_w = 16'h5555;
    tick();
    check("en0_rd_valid", 32'(rd_valid), 32'd0);
    check("en0_err", 32'(err), 32'd0);
    check("en0_d_r_held", 32'(d_r), 32'h4444);
    en = 1'b1;
    do_read(5'h02);
    check("en0_mem_kept", 32'(d_r), 32'h7777);

    // Out-of-range rows on the 6-row instance
    we = 1'b1; addr_w = 5'h05; d_w = 16'h6666;
    tick();
    we = 1'b1; addr_w = 5'h06; d_w = 16'hDEAD;
    tick();
    check("oor_wr_err6", 32'(err6), 32'd1);
    check("inrange_wr_err", 32'(err), 32'd0);
    we = 1'b0;
    tick();
    check("oor_err6_one_cycle", 32'(err6), 32'd0);
    do_read(5'h00);
    check("oor_row0_intact", 32'(d_r6), 32'h0);
    do_read(5'h05);
    check("oor_row5_intact", 32'(d_r6), 32'h6666);
    we = 1'b1; addr_w = 5'h01; d_w = 16'h1111; re = 1'b1; addr_r = 5'h07;
    tick();
    check("oor_rd_valid6", 32'(rd_valid6), 32'd0);
    check("oor_rd_err6", 32'(err6), 32'd1);
    check("oor_rd_held6", 32'(d_r6), 32'h6666);
    we = 1'b0;
    do_read(5'h01);
    check("oor_other_port6", 32'(d_r6), 32'h1111);
    check("oor_other_valid6", 32'(rd_valid6), 32'd1);

    // Reset mid-INIT restarts the full clear pass
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick(); tick(); tick();
    check("midinit_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    count_busy(bcnt, seen);
    check("midinit_restart_cycles", 32'(bcnt), 32'd8);

    // Reset in READY re-clears memory; writes during INIT are dropped
    we = 1'b1; addr_w = 5'h05; d_w = 16'hAAAA;
    tick();
    we = 1'b0;
    do_read(5'h05);
    check("pre_rst_05", 32'(d_r), 32'hAAAA);
    rst = 1'b1; we = 1'b1; re = 1'b1; addr_w = 5'h05; addr_r = 5'h05; d_w = 16'h5A5A;
    tick();
    check("rst_prio_d_r", 32'(d_r), 32'h0);
    check("rst_prio_valid", 32'(rd_valid), 32'd0);
    rst = 1'b0;
    count_busy(bcnt, seen);
    check("reinit_cycles", 32'(bcnt), 32'd8);
    check("reinit_ignored_flags", 32'(seen), 32'd0);
    do_read(5'h05);
    check("reinit_05_cleared", 32'(d_r), 32'h0);
    check("reinit_05_valid", 32'(rd_valid), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_ram_bank.md
MULTI_RAM_BANK -- requirements
Module: multi_ram_bank

Interface
REQ-001 Parameters SHALL be:
  ADDR_BIT  3  row-address width per bank
  DATA_BIT  16  word width
  MEM_HEIGHT  8  rows per bank, 1..2^ADDR_BIT
  NUM_BANKS  4  bank count, 1..16
  BANK_BIT  derived = max(1, clog2(NUM_BANKS))  bank-select width
REQ-002 Ports SHALL be:
  clk  in  1  single clock, rising edge
  rst  in  1  reset, synchronous, active-high
  en  in  1  global access enable
  we  in  1  write request
  re  in  1  read request
  addr_w  in  BANK_BIT+ADDR_BIT  write address {bank, row}
  d_w  in  DATA_BIT  write data
  addr_r  in  BANK_BIT+ADDR_BIT  read address {bank, row}
  d_r  out  DATA_BIT  registered read data
  rd_valid  out  1  d_r updated by a read this cycle
  busy  out  1  initialisation in progress
  err  out  1  one-cycle pulse, out-of-range access

Function
REQ-003 The FSM SHALL have two states: INIT and READY.
REQ-004 INIT SHALL clear row N of every bank in parallel on cycle N, for N = 0..MEM_HEIGHT-1; it SHALL enter READY on the edge after row MEM_HEIGHT-1 is cleared.
REQ-005 busy SHALL be 1 in INIT and 0 in READY.
REQ-006 Requests in INIT SHALL be ignored: no write, rd_valid=0, err=0.
REQ-007 A write SHALL occur at the clock edge when all hold: READY, en=1, we=1, bank<NUM_BANKS, row<MEM_HEIGHT.
REQ-008 A read SHALL be accepted when all hold: READY, en=1, re=1, bank<NUM_BANKS, row<MEM_HEIGHT.
REQ-009 Read latency SHALL be one cycle: d_r and rd_valid=1 appear on the cycle after acceptance.
REQ-010 When no read is accepted, d_r SHALL hold its value and rd_valid SHALL be 0.
REQ-011 On a same-cycle write and read of the same address, d_r SHALL return the new d_w (write-first).
REQ-012 Same-cycle write and read of different addresses, including different banks, SHALL both complete without stall.
REQ-013 When en=1 in READY and a requested address is out of range, that access SHALL be dropped and err SHALL pulse 1 on the next cycle. A valid access on the other port SHALL still complete.
REQ-014 With en=0, memory, d_r and all flags SHALL be unaffected; rd_valid=0 and err=0 on the next cycle.

Reset
REQ-015 With rst=1 at an edge, the block SHALL enter INIT with the row counter at 0, d_r=0, rd_valid=0, err=0 and busy=1.
REQ-016 rst asserted mid-INIT SHALL restart clearing from row 0.
REQ-017 rst asserted in READY SHALL re-clear all memory through a full INIT pass.
REQ-018 rst SHALL take priority over any concurrent write or read.

Structure
REQ-019 A shared package multi_ram_bank_pkg SHALL hold the INIT/READY state encoding and the BANK_BIT derivation function.
REQ-020 Per-bank storage SHALL be a sub-module bank_mem with one write port and one registered read port. It SHALL be instantiated NUM_BANKS times through a generate loop.

Verification (defaults unless stated; address shown as 5-bit hex)
REQ-021 rst for 1 cycle -> busy=1 for exactly 8 cycles, then 0. Reads of all 32 addresses -> d_r=0x0000 with rd_valid=1 one cycle after each read.
REQ-022 Write 0x0A with 0x1234, then read 0x0A on the next cycle -> d_r=0x1234 and rd_valid=1 one cycle later. Read 0x1A -> 0x0000, confirming bank isolation.
REQ-023 Same-cycle write 0x13 with 0xBEEF and read 0x13 -> next cycle d_r=0xBEEF, rd_valid=1.
REQ-024 Instance with MEM_HEIGHT=6: write row 6 -> err=1 for one cycle and memory unchanged. Read row 7 -> rd_valid=0, err=1, d_r held.
REQ-025 rst at INIT cycle 3 -> busy stays 1 for 8 further cycles. Write 0x05 with 0xAAAA, then rst in READY -> after INIT, read 0x05 returns 0x0000.
REQ-026 en=0 with we=1, re=1, addr 0x02, d_w 0x5555 -> later read 0x02 returns the prior value; rd_valid=0 during en=0.
